fifo_byte_packer: RTL and testbench

Downstream consumer of synchronous_fifo_counter. Drains bytes from the FIFO read port, packs PACK consecutive bytes into one wide word (first byte in the LSB lane), and presents the word on a valid/ready output interface. A flush input emits a partial word when the byte stream ends before a word is complete.

---
 rtl/fifo_byte_packer_if.sv | 26 ++
 rtl/fifo_byte_packer.sv | 95 +++++++++
 tb/tb_fifo_byte_packer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_byte_packer_if.sv
// FIFO read port plus packed-word valid/ready output of the byte packer.
// master = packer side, slave = FIFO/consumer side.
interface fifo_byte_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int CNT_W      = $clog2(PACK + 1)
);
    logic                       fifo_empty;
    logic                       fifo_r_en;
    logic [DATA_WIDTH-1:0]      fifo_data;
    logic                       flush;
    logic [DATA_WIDTH*PACK-1:0] out_data;
    logic [CNT_W-1:0]           out_count;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_r_en, out_data, out_count, out_valid
    );

    modport slave (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_r_en, out_data, out_count, out_valid
    );
endinterface

// File: rtl/fifo_byte_packer.sv
// Packs PACK FIFO bytes (first byte in lane 0) into one word; full word 2 cycles after last pop.
// Backpressure: a presented word holds until out_ready; no FIFO reads while a word or flush is pending.
module fifo_byte_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int CNT_W      = $clog2(PACK + 1)
) (
    input  logic            clk,
    input  logic            rst,
    fifo_byte_packer_if.master bus
);
    localparam int W = DATA_WIDTH * PACK;
    localparam logic [CNT_W:0]   PACK_W = (CNT_W + 1)'(PACK);
    localparam logic [CNT_W-1:0] PACK_C = CNT_W'(PACK);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             pending_q, pending_d;
    logic             flush_req_q, flush_req_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     data_q, data_d;

    logic [CNT_W:0]   inflight;
    logic             rd_en;
    logic             full_capture;

    // Bytes already read or in flight; one extra bit so cnt+pending never wraps.
    assign inflight     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pending_q};
    assign rd_en        = !rst && !bus.fifo_empty && !out_valid_q && !flush_req_q
                          && (inflight < PACK_W);
    assign full_capture = pending_q && (inflight == PACK_W);

    always_comb begin
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        pending_d   = rd_en;
        flush_req_d = flush_req_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;

        if (out_valid_q) begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
                cnt_d       = '0;
                out_count_d = '0;
                data_d      = '0;
            end
        end else begin
            if (pending_q) begin
                for (int i = 0; i < PACK; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end

            // A completing full word takes priority over any flush request.
            if (full_capture) begin
                out_valid_d = 1'b1;
                out_count_d = PACK_C;
                flush_req_d = 1'b0;
            end else if (flush_req_q && !pending_q) begin
                out_valid_d = 1'b1;
                out_count_d = cnt_q;
                flush_req_d = 1'b0;
            end else if (bus.flush && (inflight != '0)) begin
                flush_req_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_count_q <= '0;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
            pending_q   <= pending_d;
            flush_req_q <= flush_req_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
        end
    end

    assign bus.fifo_r_en = rd_en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_data  = data_q;
endmodule

// File: tb/tb_fifo_byte_packer.sv
// Randomized and directed bench for fifo_byte_packer against a byte-stream scoreboard.
module tb_fifo_byte_packer;
    localparam int DW = 8;
    localparam int PK = 4;
    localparam int CW = $clog2(PK + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_byte_packer_if #(.DATA_WIDTH(DW), .PACK(PK), .CNT_W(CW)) bus ();

    fifo_byte_packer #(.DATA_WIDTH(DW), .PACK(PK), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: FIFO contents, bytes popped but not yet emitted, flush bookkeeping.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] popped[$];
    bit   flush_model = 0;
    bit   prev_valid  = 0;
    bit   gate_empty = 0, flush_now = 0, ready_now = 0, rst_now = 1;
    int   cyc = 0, last_full_cyc = 0, rd_total = 0, word_cnt = 0, valid_cyc = 0;
    int   total_in = 0, total_out = 0;
    logic [DW*PK-1:0] last_word, held_data;
    logic [CW-1:0]    last_count, held_count;

    task automatic push(input logic [DW-1:0] b);
        fq.push_back(b);
        total_in++;
    endtask

    task automatic step();
        logic [DW*PK-1:0] exp_w;
        bit hs, rd;
        @(negedge clk);
        rst            = rst_now;
        bus.fifo_empty = (fq.size() == 0) || gate_empty;
        bus.flush      = flush_now;
        bus.out_ready  = ready_now;
        #1;
        cyc++;
        check_eq("rd_while_empty", bus.fifo_r_en & bus.fifo_empty, 0);
        check_eq("rd_while_valid", bus.fifo_r_en & bus.out_valid, 0);
        if (rst_now)     check_eq("rd_in_reset", bus.fifo_r_en, 0);
        if (flush_model) check_eq("rd_while_flush", bus.fifo_r_en, 0);
        if (bus.out_valid) valid_cyc++;
        if (bus.out_valid && !prev_valid) begin
            exp_w = '0;
            foreach (popped[i]) exp_w[i*DW +: DW] = popped[i];
            check_eq("word_count", bus.out_count, popped.size());
            check_eq("word_data", bus.out_data, exp_w);
            check_eq("word_nonempty", popped.size() > 0, 1);
            if (!flush_model) check_eq("word_full", bus.out_count, PK);
            if (popped.size() == PK) check_eq("full_latency", cyc - last_full_cyc, 2);
            flush_model = 0;
            word_cnt++;
            total_out += popped.size();
            last_word  = bus.out_data;
            last_count = bus.out_count;
            held_data  = bus.out_data;
            held_count = bus.out_count;
        end else if (bus.out_valid && prev_valid) begin
            check_eq("hold_data", bus.out_data, held_data);
            check_eq("hold_count", bus.out_count, held_count);
        end
        hs = bus.out_valid && ready_now;
        rd = bus.fifo_r_en;
        if (!rst_now && flush_now && !bus.out_valid && popped.size() > 0 && popped.size() < PK)
            flush_model = 1;
        prev_valid = bus.out_valid && !hs;
        @(posedge clk);
        #1;
        if (rst_now) begin
            total_in -= popped.size();
            popped.delete();
            flush_model = 0;
            prev_valid  = 0;
            check_eq("rst_valid", bus.out_valid, 0);
            check_eq("rst_data", bus.out_data, 0);
            check_eq("rst_count", bus.out_count, 0);
        end else begin
            if (hs) popped.delete();
            if (rd && fq.size() > 0) begin
                bus.fifo_data = fq.pop_front();
                popped.push_back(bus.fifo_data);
                rd_total++;
                if (popped.size() == PK) last_full_cyc = cyc;
            end
        end
        flush_now = 0;
    endtask

    task automatic wait_word(input string tag, input int budget);
        int start = word_cnt;
        for (int i = 0; i < budget && word_cnt == start; i++) step();
        check_eq(tag, word_cnt, start + 1);
    endtask

    task automatic wait_reads(input int n, input int budget);
        int start = rd_total;
        for (int i = 0; i < budget && rd_total < start + n; i++) step();
        check_eq("read_wait", rd_total, start + n);
    endtask

    initial begin
        int s, v;
        bus.fifo_data  = '0;
        bus.fifo_empty = 1'b1;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;

        rst_now = 1; step(); step(); rst_now = 0;

        // Single full word, one-cycle valid pulse.
        ready_now = 1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        s = rd_total; v = valid_cyc;
        wait_word("t1_wait", 20);
        check_eq("t1_word", last_word, 32'h44332211);
        check_eq("t1_count", last_count, 4);
        check_eq("t1_reads", rd_total - s, 4);
        step(); step(); step();
        check_eq("t1_pulse", valid_cyc - v, 1);

        // Held word under backpressure, then second word.
        ready_now = 0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_word("t2_wait1", 20);
        check_eq("t2_word1", last_word, 32'h04030201);
        repeat (5) step();
        ready_now = 1;
        wait_word("t2_wait2", 20);
        check_eq("t2_word2", last_word, 32'h08070605);
        step();

        // Toggling empty flag.
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        s = word_cnt;
        for (int i = 0; i < 40 && word_cnt == s; i++) begin
            gate_empty = i[0];
            step();
        end
        gate_empty = 0;
        check_eq("t3_seen", word_cnt, s + 1);
        check_eq("t3_word", last_word, 32'hA3A2A1A0);
        step();

        // Partial flush, then flush with nothing buffered.
        push(8'h5A); push(8'hC3);
        wait_reads(2, 10);
        step(); step();
        flush_now = 1;
        wait_word("t4_wait", 10);
        check_eq("t4_word", last_word, 32'h0000C35A);
        check_eq("t4_count", last_count, 2);
        step(); step();
        s = word_cnt;
        flush_now = 1;
        repeat (6) step();
        check_eq("t4_noword", word_cnt, s);

        // Flush while the second byte is still in flight.
        push(8'h9E); push(8'h3D);
        wait_reads(2, 10);
        flush_now = 1;
        wait_word("t5_wait", 10);
        check_eq("t5_count", last_count, 2);
        check_eq("t5_word", last_word, 32'h00003D9E);
        ready_now = 0;
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        repeat (4) step();
        ready_now = 1;
        wait_word("t5_next", 20);
        check_eq("t5_next_word", last_word, 32'h64636261);
        step();

        // Mid-operation reset discards a partial word.
        push(8'h71); push(8'h72); push(8'h73);
        wait_reads(3, 10);
        step(); step();
        rst_now = 1; step(); rst_now = 0;
        total_in -= fq.size();
        fq.delete();
        push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
        wait_word("t6_wait", 20);
        check_eq("t6_word", last_word, 32'hB3B2B1B0);
        step();

        // Random traffic with backpressure, empty gaps and flushes.
        for (int i = 0; i < 1500; i++) begin
            if (fq.size() < 6 && $urandom_range(0, 1) == 1) push(8'($urandom));
            gate_empty = ($urandom_range(0, 3) == 0);
            ready_now  = ($urandom_range(0, 9) < 7);
            flush_now  = ($urandom_range(0, 99) < 3);
            step();
        end
        gate_empty = 0;
        ready_now  = 1;
        repeat (15) step();
        flush_now = 1;
        repeat (15) step();
        check_eq("drain_fifo", fq.size(), 0);
        check_eq("drain_bytes", total_out, total_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
